// File: rtl/psum_pkg.sv
// Shared types, width relations and saturation limits for the partial-sum drain.
package psum_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int unsigned BW_DEF  = 8;
    localparam int unsigned CNT_DEF = 8;

    function automatic int unsigned psum_width(input int unsigned bw);
        return 2 * bw + 3;
    endfunction

    function automatic int unsigned acc_width(input int unsigned bw_psum);
        return bw_psum + 5;
    endfunction

    // Limits are returned 64 bits wide; callers truncate to their accumulator width.
    function automatic logic [63:0] sat_max(input int unsigned w, input logic sgn);
        if (sgn)
            return (64'd1 << (w - 1)) - 64'd1;
        else if (w >= 64)
            return '1;
        else
            return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned w, input logic sgn);
        if (sgn)
            return {64{1'b1}} << (w - 1);
        else
            return '0;
    endfunction

endpackage

// File: rtl/psum_sat_add.sv
// Combinational extend-and-saturating-add of one partial sum into an accumulator.
module psum_sat_add
    import psum_pkg::*;
#(
    parameter int unsigned bw_psum = 19,
    parameter int unsigned acc_bw  = 24
) (
    input  logic [acc_bw-1:0]  acc,
    input  logic [bw_psum-1:0] psum,
    input  logic               is_signed,
    output logic [acc_bw-1:0]  sum,
    output logic               sat
);

    localparam int unsigned EXT_BW = acc_bw - bw_psum;
    localparam logic [acc_bw-1:0] MAX_S = acc_bw'(sat_max(acc_bw, 1'b1));
    localparam logic [acc_bw-1:0] MIN_S = acc_bw'(sat_min(acc_bw, 1'b1));
    localparam logic [acc_bw-1:0] MAX_U = acc_bw'(sat_max(acc_bw, 1'b0));

    logic [acc_bw-1:0] ext;
    logic [acc_bw:0]   raw;
    logic              pos_ovf;
    logic              neg_ovf;

    assign ext = is_signed ? {{EXT_BW{psum[bw_psum-1]}}, psum}
                           : {{EXT_BW{1'b0}}, psum};
    assign raw = {1'b0, acc} + {1'b0, ext};

    // Signed overflow only when both operands share a sign the result lost.
    assign pos_ovf = ~acc[acc_bw-1] & ~ext[acc_bw-1] &  raw[acc_bw-1];
    assign neg_ovf =  acc[acc_bw-1] &  ext[acc_bw-1] & ~raw[acc_bw-1];

    always_comb begin
        sum = raw[acc_bw-1:0];
        sat = 1'b0;
        if (is_signed) begin
            if (pos_ovf) begin
                sum = MAX_S;
                sat = 1'b1;
            end else if (neg_ovf) begin
                sum = MIN_S;
                sat = 1'b1;
            end
        end else if (raw[acc_bw]) begin
            sum = MAX_U;
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/psum_acc_drain.sv
// Accumulates num_chunks partial sums per result and drains them on a valid/ready port.
// Optional build macro PSUM_ACC_RELU_EN clamps negative signed results to zero.
module psum_acc_drain
    import psum_pkg::*;
#(
    parameter int unsigned bw      = BW_DEF,
    parameter int unsigned bw_psum = psum_width(bw),
    parameter int unsigned acc_bw  = acc_width(bw_psum),
    parameter int unsigned cnt_bw  = CNT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [bw_psum-1:0] in_psum,
    input  logic               is_signed,
    input  logic [cnt_bw-1:0]  num_chunks,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [acc_bw-1:0]  out_acc,
    output logic               out_sat,
    output logic               busy
);

    state_t            state;
    logic [acc_bw-1:0] acc;
    logic [cnt_bw-1:0] cnt;
    logic [cnt_bw-1:0] n_lat;
    logic              signed_lat;
    logic              sat;

    logic              beat;
    logic              start_group;
    logic              last;
    logic              sgn_eff;
    logic [cnt_bw-1:0] n_eff;
    logic [acc_bw-1:0] add_acc;
    logic [acc_bw-1:0] sum;
    logic              sum_sat;
    logic              sat_next;
    logic [acc_bw-1:0] result;

    assign in_ready = !reset && ((state != HOLD) || out_ready);
    assign beat     = in_valid && in_ready;

    // A beat outside ACCUM always opens a new group, including the zero-bubble HOLD case.
    assign start_group = beat && (state != ACCUM);
    assign sgn_eff     = start_group ? is_signed : signed_lat;
    assign n_eff       = (num_chunks == '0) ? cnt_bw'(1) : num_chunks;
    assign add_acc     = start_group ? '0 : acc;
    assign last        = start_group ? (n_eff == cnt_bw'(1))
                                     : ((cnt + cnt_bw'(1)) == n_lat);
    assign sat_next    = start_group ? sum_sat : (sat | sum_sat);

    psum_sat_add #(
        .bw_psum (bw_psum),
        .acc_bw  (acc_bw)
    ) u_sat_add (
        .acc       (add_acc),
        .psum      (in_psum),
        .is_signed (sgn_eff),
        .sum       (sum),
        .sat       (sum_sat)
    );

`ifdef PSUM_ACC_RELU_EN
    assign result = (sgn_eff && sum[acc_bw-1]) ? '0 : sum;
`else
    assign result = sum;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            n_lat      <= '0;
            signed_lat <= 1'b0;
            sat        <= 1'b0;
            out_valid  <= 1'b0;
            out_acc    <= '0;
            out_sat    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM, HOLD: begin
                    if (beat) begin
                        acc  <= sum;
                        sat  <= sat_next;
                        busy <= 1'b1;
                        cnt  <= start_group ? cnt_bw'(1) : cnt + cnt_bw'(1);
                        if (start_group) begin
                            n_lat      <= n_eff;
                            signed_lat <= is_signed;
                        end
                        if (last) begin
                            state     <= HOLD;
                            out_valid <= 1'b1;
                            out_acc   <= result;
                            out_sat   <= sat_next;
                        end else begin
                            state     <= ACCUM;
                            out_valid <= 1'b0;
                        end
                    end else if (state == HOLD && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
